// File: rtl/codec_pkg.sv
// Shared constants for the I2S codec-side serial link.
//   DATA_W_DEFAULT : default sample width per channel
//   I2S_DELAY      : slot bit index of the first data bit (one-bit delay)
//   LEFT / RIGHT   : LRCLK level for each channel
package codec_pkg;

    localparam int unsigned DATA_W_DEFAULT = 24;
    localparam int unsigned I2S_DELAY      = 1;

    localparam logic LEFT  = 1'b0;
    localparam logic RIGHT = 1'b1;

endpackage

// File: rtl/codec_serial_slave_sync_edge.sv
// Two-flop synchronizer with single-cycle rise/fall strobes taken against a
// third flop. Used for the asynchronous serial-link inputs.
//   clk, rst : system clock, synchronous active-high reset
//   d_i      : asynchronous input
//   q_o      : synchronized level
//   rise_o   : one-clk strobe on a synchronized 0->1 transition
//   fall_o   : one-clk strobe on a synchronized 1->0 transition
module sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign q_o    = sync_q;
    assign rise_o = sync_q & ~prev_q;
    assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/codec_serial_slave.sv
// Codec-side (slave) endpoint of an I2S link. SCLK/LRCLK/RSTn come from the
// master; ADC samples are shifted out on SDout, DAC samples on SDin are
// collected into parallel stereo words.
//   clk, rst          : system clock, synchronous active-high reset
//   RSTn              : link enable from master (low = idle)
//   SCLK, LRCLK, SDin : serial link inputs, asynchronous to clk
//   SDout             : ADC serial data to master
//   adc_lft, adc_rht  : ADC pair to transmit; adc_req pulses when captured
//   dac_lft, dac_rht  : last complete DAC pair; dac_valid pulses on update
module codec_serial_slave
    import codec_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEFAULT,
    parameter int unsigned SLOT_MAX = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RSTn,
    input  logic              SCLK,
    input  logic              LRCLK,
    input  logic              SDin,
    output logic              SDout,
    input  logic [DATA_W-1:0] adc_lft,
    input  logic [DATA_W-1:0] adc_rht,
    output logic              adc_req,
    output logic [DATA_W-1:0] dac_lft,
    output logic [DATA_W-1:0] dac_rht,
    output logic              dac_valid
);

    localparam int unsigned      CNT_W     = $clog2(SLOT_MAX);
    localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(SLOT_MAX - 1);
    localparam logic [CNT_W-1:0] BIT_FIRST = CNT_W'(I2S_DELAY);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(DATA_W + I2S_DELAY - 1);

    logic sclk_lvl_unused, sclk_rise, sclk_fall;
    logic lr_s, lr_rise_unused, lr_fall_unused;
    logic sd_s, sd_rise_unused, sd_fall_unused;

    sync_edge u_sync_sclk (
        .clk(clk), .rst(rst), .d_i(SCLK),
        .q_o(sclk_lvl_unused), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );
    sync_edge u_sync_lrclk (
        .clk(clk), .rst(rst), .d_i(LRCLK),
        .q_o(lr_s), .rise_o(lr_rise_unused), .fall_o(lr_fall_unused)
    );
    sync_edge u_sync_sdin (
        .clk(clk), .rst(rst), .d_i(SDin),
        .q_o(sd_s), .rise_o(sd_rise_unused), .fall_o(sd_fall_unused)
    );

    // RSTn is also asynchronous to clk.
    logic rstn_meta_q, rstn_q;

    logic              lr_prev_q,  lr_prev_d;
    logic [CNT_W-1:0]  cnt_q,      cnt_d;
    logic              armed_q,    armed_d;    // a left start has been seen
    logic              chan_q,     chan_d;
    logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
    logic [DATA_W-1:0] hold_r_q,   hold_r_d;
    logic              adc_req_q,  adc_req_d;
    logic              sdout_q,    sdout_d;
    logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_W-1:0] rx_left_q,  rx_left_d;
    logic              left_ok_q,  left_ok_d;  // full left word captured
    logic [DATA_W-1:0] dac_l_q,    dac_l_d;
    logic [DATA_W-1:0] dac_r_q,    dac_r_d;
    logic              dac_vld_q,  dac_vld_d;

    always_comb begin
        lr_prev_d  = lr_prev_q;
        cnt_d      = cnt_q;
        armed_d    = armed_q;
        chan_d     = chan_q;
        tx_shift_d = tx_shift_q;
        hold_r_d   = hold_r_q;
        adc_req_d  = 1'b0;
        sdout_d    = sdout_q;
        rx_shift_d = rx_shift_q;
        rx_left_d  = rx_left_q;
        left_ok_d  = left_ok_q;
        dac_l_d    = dac_l_q;
        dac_r_d    = dac_r_q;
        dac_vld_d  = 1'b0;

        if (!rstn_q) begin
            // Link idle: behaves like rst except the DAC outputs hold.
            lr_prev_d  = 1'b0;
            cnt_d      = '0;
            armed_d    = 1'b0;
            chan_d     = LEFT;
            tx_shift_d = '0;
            hold_r_d   = '0;
            sdout_d    = 1'b0;
            rx_shift_d = '0;
            rx_left_d  = '0;
            left_ok_d  = 1'b0;
        end else begin
            if (sclk_fall) begin
                lr_prev_d = lr_s;
                if (lr_s != lr_prev_q) begin
                    cnt_d   = '0;
                    sdout_d = 1'b0;
                    if (lr_s == LEFT) begin
                        // Only the right word needs holding: the left word
                        // goes straight into the shifter on this same clk.
                        armed_d    = 1'b1;
                        chan_d     = LEFT;
                        hold_r_d   = adc_rht;
                        tx_shift_d = adc_lft;
                        adc_req_d  = 1'b1;
                        left_ok_d  = 1'b0;
                    end else if (armed_q) begin
                        chan_d     = RIGHT;
                        tx_shift_d = hold_r_q;
                    end
                end else begin
                    cnt_d = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;
                    if (armed_q && cnt_d >= BIT_FIRST && cnt_d <= BIT_LAST) begin
                        sdout_d    = tx_shift_q[DATA_W-1];
                        tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
                    end else begin
                        sdout_d = 1'b0;
                    end
                end
            end

            if (sclk_rise && armed_q && cnt_q >= BIT_FIRST && cnt_q <= BIT_LAST) begin
                rx_shift_d = {rx_shift_q[DATA_W-2:0], sd_s};
                if (cnt_q == BIT_LAST) begin
                    if (chan_q == LEFT) begin
                        rx_left_d = rx_shift_d;
                        left_ok_d = 1'b1;
                    end else if (left_ok_q) begin
                        dac_l_d   = rx_left_q;
                        dac_r_d   = rx_shift_d;
                        dac_vld_d = 1'b1;
                        left_ok_d = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rstn_meta_q <= 1'b0;
            rstn_q      <= 1'b0;
            lr_prev_q   <= 1'b0;
            cnt_q       <= '0;
            armed_q     <= 1'b0;
            chan_q      <= LEFT;
            tx_shift_q  <= '0;
            hold_r_q    <= '0;
            adc_req_q   <= 1'b0;
            sdout_q     <= 1'b0;
            rx_shift_q  <= '0;
            rx_left_q   <= '0;
            left_ok_q   <= 1'b0;
            dac_l_q     <= '0;
            dac_r_q     <= '0;
            dac_vld_q   <= 1'b0;
        end else begin
            rstn_meta_q <= RSTn;
            rstn_q      <= rstn_meta_q;
            lr_prev_q   <= lr_prev_d;
            cnt_q       <= cnt_d;
            armed_q     <= armed_d;
            chan_q      <= chan_d;
            tx_shift_q  <= tx_shift_d;
            hold_r_q    <= hold_r_d;
            adc_req_q   <= adc_req_d;
            sdout_q     <= sdout_d;
            rx_shift_q  <= rx_shift_d;
            rx_left_q   <= rx_left_d;
            left_ok_q   <= left_ok_d;
            dac_l_q     <= dac_l_d;
            dac_r_q     <= dac_r_d;
            dac_vld_q   <= dac_vld_d;
        end
    end

    assign SDout     = sdout_q;
    assign adc_req   = adc_req_q;
    assign dac_lft   = dac_l_q;
    assign dac_rht   = dac_r_q;
    assign dac_valid = dac_vld_q;

endmodule

// File: tb/tb_codec_serial_slave.sv
// Bench for codec_serial_slave: acts as the I2S master (clk = 8x SCLK,
// 32-bit slots), captures SDout on SCLK rising edges and collects DAC pairs.
module tb_codec_serial_slave;
    import codec_pkg::*;

    localparam int DW   = 24;
    localparam int SLOT = 32;

    logic          clk = 1'b0;
    logic          rst, RSTn, SCLK, LRCLK, SDin, SDout;
    logic [DW-1:0] adc_lft, adc_rht, dac_lft, dac_rht;
    logic          adc_req, dac_valid;

    always #5 clk = ~clk;

    codec_serial_slave #(.DATA_W(DW), .SLOT_MAX(SLOT)) dut (
        .clk(clk), .rst(rst), .RSTn(RSTn), .SCLK(SCLK), .LRCLK(LRCLK),
        .SDin(SDin), .SDout(SDout), .adc_lft(adc_lft), .adc_rht(adc_rht),
        .adc_req(adc_req), .dac_lft(dac_lft), .dac_rht(dac_rht),
        .dac_valid(dac_valid)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Observed activity, sampled away from the active edge.
    int                req_cnt = 0;
    logic [2*DW-1:0]   got_q[$];
    always @(negedge clk) begin
        if (adc_req === 1'b1) req_cnt++;
        if (dac_valid === 1'b1) got_q.push_back({dac_lft, dac_rht});
    end

    // Reference model state: DAC outputs the bench expects to see held.
    logic [DW-1:0] exp_dl = '0;
    logic [DW-1:0] exp_dr = '0;

    // I2S slot content for bit b of a channel carrying word.
    function automatic logic slot_bit(input logic [DW-1:0] word, input int b);
        if (b >= 1 && b <= DW) return word[DW-b];
        return 1'b0;
    endfunction

    // Whole slot as the master would capture it, bit 0 first (in MSB).
    function automatic logic [SLOT-1:0] exp_slot(input logic [DW-1:0] word);
        logic [SLOT-1:0] s;
        for (int b = 0; b < SLOT; b++) s[SLOT-1-b] = slot_bit(word, b);
        return s;
    endfunction

    // One channel of nbits SCLK periods; optional 1-clk rst at bit rst_bit.
    task automatic run_channel(input logic lr, input logic [DW-1:0] word,
                               input int nbits, input int rst_bit,
                               output logic [SLOT-1:0] cap);
        cap = '0;
        for (int b = 0; b < nbits; b++) begin
            @(negedge clk);
            SCLK  = 1'b0;
            LRCLK = lr;
            SDin  = slot_bit(word, b);
            if (b == rst_bit) rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            repeat (3) @(negedge clk);
            SCLK = 1'b1;
            if (b < SLOT) cap[SLOT-1-b] = SDout;
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic run_frame(input logic [DW-1:0] tl, input logic [DW-1:0] tr,
                             input logic [DW-1:0] rl, input logic [DW-1:0] rr,
                             input int lb, input int rb, input int rst_bit,
                             output logic [SLOT-1:0] lcap, output logic [SLOT-1:0] rcap,
                             output int nreq);
        int r0;
        adc_lft = tl;
        adc_rht = tr;
        r0 = req_cnt;
        run_channel(LEFT,  rl, lb, rst_bit, lcap);
        run_channel(RIGHT, rr, rb, -1,      rcap);
        nreq = req_cnt - r0;
    endtask

    // Raise RSTn and send a short right channel first; it must be ignored.
    task automatic link_up();
        logic [SLOT-1:0] cap;
        int r0;
        RSTn = 1'b1;
        repeat (4) @(negedge clk);
        r0 = req_cnt;
        run_channel(RIGHT, DW'($urandom), 4, -1, cap);
        n_cmp++;
        if (cap !== '0 || req_cnt != r0 || got_q.size() != 0) begin
            n_bad++;
            $display("FAIL right_first_ignored: sdout %h req %0d valids %0d, want 0/0/0",
                     cap, req_cnt - r0, got_q.size());
        end
    endtask

    task automatic test_reset();
        logic [SLOT-1:0] lc, rc;
        int nr;
        rst = 1'b1; RSTn = 1'b0; SCLK = 1'b1; LRCLK = 1'b1; SDin = 1'b0;
        adc_lft = '0; adc_rht = '0;
        repeat (5) @(negedge clk);
        n_cmp++; if (SDout !== 1'b0) begin n_bad++; $display("FAIL rst_sdout: got %b want 0", SDout); end
        n_cmp++; if (adc_req !== 1'b0) begin n_bad++; $display("FAIL rst_adc_req: got %b want 0", adc_req); end
        n_cmp++; if (dac_valid !== 1'b0) begin n_bad++; $display("FAIL rst_dac_valid: got %b want 0", dac_valid); end
        n_cmp++; if (dac_lft !== '0) begin n_bad++; $display("FAIL rst_dac_lft: got %h want 0", dac_lft); end
        n_cmp++; if (dac_rht !== '0) begin n_bad++; $display("FAIL rst_dac_rht: got %h want 0", dac_rht); end
        rst = 1'b0;
        // Link idle with the master clocking: no activity at all.
        for (int f = 0; f < 2; f++) begin
            run_frame(DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom),
                      SLOT, SLOT, -1, lc, rc, nr);
            n_cmp++;
            if (lc !== '0 || rc !== '0 || nr != 0 || got_q.size() != 0) begin
                n_bad++;
                $display("FAIL idle_quiet f%0d: sdout %h/%h req %0d valids %0d, want all 0",
                         f, lc, rc, nr, got_q.size());
            end
        end
        n_cmp++;
        if (dac_lft !== '0 || dac_rht !== '0) begin
            n_bad++;
            $display("FAIL idle_dac: got %h/%h want 0/0", dac_lft, dac_rht);
        end
    endtask

    task automatic test_tx_pattern();
        logic [SLOT-1:0] lc, rc;
        logic [DW-1:0]   rl, rr;
        logic [2*DW-1:0] p;
        int nr;
        link_up();
        for (int f = 0; f < 2; f++) begin
            rl = DW'($urandom); rr = DW'($urandom);
            run_frame(24'hA5F00F, 24'h123456, rl, rr, SLOT, SLOT, -1, lc, rc, nr);
            n_cmp++; if (lc !== exp_slot(24'hA5F00F)) begin n_bad++; $display("FAIL tx_left f%0d: got %h want %h", f, lc, exp_slot(24'hA5F00F)); end
            n_cmp++; if (rc !== exp_slot(24'h123456)) begin n_bad++; $display("FAIL tx_right f%0d: got %h want %h", f, rc, exp_slot(24'h123456)); end
            n_cmp++; if (nr != 1) begin n_bad++; $display("FAIL tx_adc_req f%0d: got %0d pulses want 1", f, nr); end
            n_cmp++;
            if (got_q.size() != 1) begin
                n_bad++; $display("FAIL tx_valids f%0d: got %0d want 1", f, got_q.size());
                got_q.delete();
            end else begin
                p = got_q.pop_front();
                if (p !== {rl, rr}) begin n_bad++; $display("FAIL tx_rx_pair f%0d: got %h want %h", f, p, {rl, rr}); end
            end
            exp_dl = rl; exp_dr = rr;
        end
    endtask

    task automatic test_rx_pattern();
        logic [SLOT-1:0] lc, rc;
        logic [DW-1:0]   tl, tr;
        logic [2*DW-1:0] p;
        int nr;
        tl = DW'($urandom); tr = DW'($urandom);
        run_frame(tl, tr, 24'h800001, 24'h7FFFFE, SLOT, SLOT, -1, lc, rc, nr);
        exp_dl = 24'h800001; exp_dr = 24'h7FFFFE;
        n_cmp++;
        if (got_q.size() != 1) begin
            n_bad++; $display("FAIL rx_valids: got %0d want 1", got_q.size());
            got_q.delete();
        end else begin
            p = got_q.pop_front();
            if (p !== {exp_dl, exp_dr}) begin n_bad++; $display("FAIL rx_pair_at_valid: got %h want %h", p, {exp_dl, exp_dr}); end
        end
        n_cmp++; if (dac_lft !== exp_dl) begin n_bad++; $display("FAIL rx_dac_lft: got %h want %h", dac_lft, exp_dl); end
        n_cmp++; if (dac_rht !== exp_dr) begin n_bad++; $display("FAIL rx_dac_rht: got %h want %h", dac_rht, exp_dr); end
        n_cmp++; if (lc !== exp_slot(tl) || rc !== exp_slot(tr)) begin n_bad++; $display("FAIL rx_tx_slots: got %h/%h want %h/%h", lc, rc, exp_slot(tl), exp_slot(tr)); end
    endtask

    // Samples sent on SDin equal the ADC samples of the same frame.
    task automatic test_loopback_random();
        logic [SLOT-1:0] lc, rc;
        logic [DW-1:0]   base, l, r;
        logic [2*DW-1:0] p;
        int nr;
        base = DW'($urandom);
        for (int f = 0; f < 4; f++) begin
            l = base + DW'(2 * f);
            r = base + DW'(2 * f + 1);
            run_frame(l, r, l, r, SLOT, SLOT, -1, lc, rc, nr);
            n_cmp++;
            if (lc !== exp_slot(l) || rc !== exp_slot(r) || nr != 1) begin
                n_bad++;
                $display("FAIL loop_tx f%0d: got %h/%h req %0d want %h/%h req 1",
                         f, lc, rc, nr, exp_slot(l), exp_slot(r));
            end
            n_cmp++;
            if (got_q.size() != 1) begin
                n_bad++; $display("FAIL loop_valids f%0d: got %0d want 1", f, got_q.size());
                got_q.delete();
            end else begin
                p = got_q.pop_front();
                if (p !== {l, r}) begin n_bad++; $display("FAIL loop_pair f%0d: got %h want %h", f, p, {l, r}); end
            end
            exp_dl = l; exp_dr = r;
        end
    endtask

    task automatic test_short_channel();
        logic [SLOT-1:0] lc, rc;
        logic [DW-1:0]   tl, tr, rl, rr;
        logic [2*DW-1:0] p;
        int nr;
        // Right channel cut after 10 data bits, then left channel cut short.
        for (int k = 0; k < 2; k++) begin
            tl = DW'($urandom); tr = DW'($urandom);
            run_frame(tl, tr, DW'($urandom), DW'($urandom),
                      (k == 0) ? SLOT : 11, (k == 0) ? 11 : SLOT, -1, lc, rc, nr);
            n_cmp++;
            if (got_q.size() != 0) begin
                n_bad++; $display("FAIL short_no_valid k%0d: got %0d valids want 0", k, got_q.size());
                got_q.delete();
            end
            n_cmp++;
            if (dac_lft !== exp_dl || dac_rht !== exp_dr) begin
                n_bad++; $display("FAIL short_hold k%0d: got %h/%h want %h/%h", k, dac_lft, dac_rht, exp_dl, exp_dr);
            end
            n_cmp++;
            if (nr != 1 || (k == 0 && lc !== exp_slot(tl)) || (k == 1 && rc !== exp_slot(tr))) begin
                n_bad++; $display("FAIL short_tx k%0d: got %h/%h req %0d", k, lc, rc, nr);
            end
        end
        tl = DW'($urandom); tr = DW'($urandom); rl = DW'($urandom); rr = DW'($urandom);
        run_frame(tl, tr, rl, rr, SLOT, SLOT, -1, lc, rc, nr);
        n_cmp++;
        if (got_q.size() != 1) begin
            n_bad++; $display("FAIL short_recover_valids: got %0d want 1", got_q.size());
            got_q.delete();
        end else begin
            p = got_q.pop_front();
            if (p !== {rl, rr}) begin n_bad++; $display("FAIL short_recover_pair: got %h want %h", p, {rl, rr}); end
        end
        exp_dl = rl; exp_dr = rr;
    endtask

    task automatic test_midframe_rst();
        logic [SLOT-1:0] lc, rc;
        logic [DW-1:0]   tl, tr, rl, rr;
        logic [2*DW-1:0] p;
        int nr;
        run_frame(DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom),
                  SLOT, SLOT, 12, lc, rc, nr);
        exp_dl = '0; exp_dr = '0;
        n_cmp++;
        if (lc[SLOT-13:0] !== '0 || rc !== '0) begin
            n_bad++; $display("FAIL midrst_sdout: got %h/%h want zero after bit 12", lc, rc);
        end
        n_cmp++;
        if (got_q.size() != 0) begin
            n_bad++; $display("FAIL midrst_no_valid: got %0d want 0", got_q.size());
            got_q.delete();
        end
        n_cmp++;
        if (dac_lft !== exp_dl || dac_rht !== exp_dr) begin
            n_bad++; $display("FAIL midrst_dac_cleared: got %h/%h want 0/0", dac_lft, dac_rht);
        end
        tl = DW'($urandom); tr = DW'($urandom); rl = DW'($urandom); rr = DW'($urandom);
        run_frame(tl, tr, rl, rr, SLOT, SLOT, -1, lc, rc, nr);
        n_cmp++;
        if (lc !== exp_slot(tl) || rc !== exp_slot(tr) || nr != 1) begin
            n_bad++; $display("FAIL midrst_recover_tx: got %h/%h req %0d want %h/%h req 1",
                              lc, rc, nr, exp_slot(tl), exp_slot(tr));
        end
        n_cmp++;
        if (got_q.size() != 1) begin
            n_bad++; $display("FAIL midrst_recover_valids: got %0d want 1", got_q.size());
            got_q.delete();
        end else begin
            p = got_q.pop_front();
            if (p !== {rl, rr}) begin n_bad++; $display("FAIL midrst_recover_pair: got %h want %h", p, {rl, rr}); end
        end
        exp_dl = rl; exp_dr = rr;
    endtask

    task automatic test_rstn_hold();
        logic [SLOT-1:0] lc, rc;
        logic [DW-1:0]   rl, rr;
        logic [2*DW-1:0] p;
        int nr;
        RSTn = 1'b0;
        run_frame(DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom),
                  SLOT, SLOT, -1, lc, rc, nr);
        n_cmp++;
        if (lc !== '0 || rc !== '0 || nr != 0 || got_q.size() != 0) begin
            n_bad++; $display("FAIL rstn_idle: sdout %h/%h req %0d valids %0d want all 0",
                              lc, rc, nr, got_q.size());
            got_q.delete();
        end
        n_cmp++;
        if (dac_lft !== exp_dl || dac_rht !== exp_dr) begin
            n_bad++; $display("FAIL rstn_dac_hold: got %h/%h want %h/%h", dac_lft, dac_rht, exp_dl, exp_dr);
        end
        link_up();
        rl = DW'($urandom); rr = DW'($urandom);
        run_frame(rl, rr, rl, rr, SLOT, SLOT, -1, lc, rc, nr);
        n_cmp++;
        if (got_q.size() != 1 || nr != 1) begin
            n_bad++; $display("FAIL rstn_recover: valids %0d req %0d want 1/1", got_q.size(), nr);
            got_q.delete();
        end else begin
            p = got_q.pop_front();
            if (p !== {rl, rr} || lc !== exp_slot(rl)) begin
                n_bad++; $display("FAIL rstn_recover_pair: got %h want %h", p, {rl, rr});
            end
        end
    endtask

    initial begin
        test_reset();
        test_tx_pattern();
        test_rx_pattern();
        test_loopback_random();
        test_short_channel();
        test_midframe_rst();
        test_rstn_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
